// File: rtl/rv32i_pkg.sv
// rv32i_pkg: opcodes, immediate format codes, controller states and select codes
// shared by the multicycle controller and the format decoder.
package rv32i_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_32     = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_R       = 3'b000,
        FMT_I       = 3'b001,
        FMT_S       = 3'b010,
        FMT_B       = 3'b011,
        FMT_U       = 3'b100,
        FMT_J       = 3'b101,
        FMT_ILLEGAL = 3'b111
    } fmt_e;

    typedef enum logic [2:0] {
        S_START,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_TRAP
    } state_e;

    localparam logic [1:0] PC_PLUS4     = 2'b00;
    localparam logic [1:0] PC_ALU       = 2'b01;
    localparam logic [1:0] PC_ALU_ALIGN = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

endpackage

// File: rtl/rv32i_multicycle_controller_if.sv
// rv32i_multicycle_controller_if: request/acknowledge handshake to the shared memory port.
interface rv32i_multicycle_controller_if;

    logic mem_req;
    logic mem_we;
    logic mem_sel;
    logic mem_ack;

    modport master (output mem_req, output mem_we, output mem_sel, input mem_ack);
    modport slave  (input mem_req, input mem_we, input mem_sel, output mem_ack);

endinterface

// File: rtl/instr_format_decode.sv
// instr_format_decode: maps a base opcode to its immediate format code.
module instr_format_decode
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [6:0] opcode,
    output fmt_e       fmt
);

    logic rv64;

    always_comb begin
        rv64 = XLEN == 64;
        // word-sized RV64 opcodes only exist when the datapath is 64 bits wide
        fmt = (opcode == OP_LUI || opcode == OP_AUIPC)                    ? FMT_U :
              (opcode == OP_JAL)                                          ? FMT_J :
              (opcode == OP_JALR || opcode == OP_LOAD ||
               opcode == OP_IMM  || opcode == OP_FENCE)                   ? FMT_I :
              (opcode == OP_BRANCH)                                       ? FMT_B :
              (opcode == OP_STORE)                                        ? FMT_S :
              (opcode == OP_OP)                                           ? FMT_R :
              (rv64 && opcode == OP_IMM_32)                               ? FMT_I :
              (rv64 && opcode == OP_32)                                   ? FMT_R :
                                                                            FMT_ILLEGAL;
    end

endmodule

// File: rtl/rv32i_multicycle_controller.sv
// rv32i_multicycle_controller: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for a
// multicycle RV32I core; outputs decode combinationally from state and opcode.
module rv32i_multicycle_controller
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [6:0]                           opcode,
    input  logic                                 branch_taken,
    rv32i_multicycle_controller_if.master        mem,
    output logic                                 ir_we,
    output logic                                 pc_we,
    output logic [1:0]                           pc_sel,
    output logic                                 reg_we,
    output logic [1:0]                           wb_sel,
    output logic                                 alu_src_a,
    output logic                                 alu_src_b,
    output logic [2:0]                           imm_format,
    output logic                                 illegal
);

    state_e state_q, state_d;
    fmt_e   fmt;
    logic   is_load, is_store, is_branch, is_fence, is_jal, is_jalr, in_instr;

    instr_format_decode #(.XLEN(XLEN)) u_fmt (
        .opcode (opcode),
        .fmt    (fmt)
    );

    always_comb begin
        is_load   = opcode == OP_LOAD;
        is_store  = opcode == OP_STORE;
        is_branch = opcode == OP_BRANCH;
        is_fence  = opcode == OP_FENCE;
        is_jal    = opcode == OP_JAL;
        is_jalr   = opcode == OP_JALR;
        in_instr  = state_q inside {S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK};
    end

    always_comb begin
        state_d     = state_q;
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        mem.mem_sel = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = PC_PLUS4;
        reg_we      = 1'b0;
        wb_sel      = WB_ALU;
        illegal     = 1'b0;
        case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: begin
                mem.mem_req = 1'b1;
                ir_we       = mem.mem_ack;
                state_d     = mem.mem_ack ? S_DECODE : S_FETCH;
            end
            S_DECODE: state_d = (fmt == FMT_ILLEGAL || opcode == OP_SYSTEM) ? S_TRAP : S_EXECUTE;
            S_EXECUTE: begin
                pc_we   = is_branch || is_fence;
                pc_sel  = (is_branch && branch_taken) ? PC_ALU : PC_PLUS4;
                state_d = (is_load || is_store)   ? S_MEMORY :
                          (is_branch || is_fence) ? S_FETCH  : S_WRITEBACK;
            end
            S_MEMORY: begin
                mem.mem_req = 1'b1;
                mem.mem_sel = 1'b1;
                mem.mem_we  = is_store;
                pc_we       = is_store && mem.mem_ack;
                state_d     = !mem.mem_ack ? S_MEMORY : is_store ? S_FETCH : S_WRITEBACK;
            end
            S_WRITEBACK: begin
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                wb_sel  = is_load ? WB_MEM : (is_jal || is_jalr) ? WB_PC4 : WB_ALU;
                pc_sel  = is_jal ? PC_ALU : is_jalr ? PC_ALU_ALIGN : PC_PLUS4;
                state_d = S_FETCH;
            end
            S_TRAP: illegal = 1'b1;
            default: state_d = S_START;
        endcase
        imm_format = in_instr ? fmt : FMT_R;
        alu_src_a  = in_instr && (opcode == OP_AUIPC || is_jal || is_branch);
        alu_src_b  = in_instr && fmt != FMT_R;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_START;
        else     state_q <= state_d;
    end

endmodule

// File: tb/tb_rv32i_multicycle_controller.sv
// tb_rv32i_multicycle_controller: per-cycle expected output traces queued per instruction
// and compared against the controller outputs one cycle at a time.
module tb_rv32i_multicycle_controller;

    typedef enum int {K_ALU, K_LOAD, K_STORE, K_BRANCH, K_FENCE, K_JAL, K_JALR} kind_e;

    typedef struct {
        string       tag;
        logic [6:0]  opc;
        logic        ack;
        logic        tk;
        logic [15:0] exp;
        logic [15:0] mask;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] opcode = 7'b0;
    logic       branch_taken = 1'b0;
    logic       ir_we, pc_we, reg_we, alu_src_a, alu_src_b, illegal;
    logic [1:0] pc_sel, wb_sel;
    logic [2:0] imm_format;
    int         n_checks = 0;
    int         n_fail = 0;
    ent_t       q[$];

    rv32i_multicycle_controller_if ifc ();

    rv32i_multicycle_controller #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem          (ifc),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .imm_format   (imm_format),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    // bit layout: req we sel ir_we pc_we pc_sel[2] reg_we wb_sel[2] a b fmt[3] illegal
    function automatic logic [15:0] obs_vec();
        return {ifc.mem_req, ifc.mem_we, ifc.mem_sel, ir_we, pc_we, pc_sel, reg_we, wb_sel,
                alu_src_a, alu_src_b, imm_format, illegal};
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic add(string tag, logic [6:0] opc, logic ack, logic tk, logic [15:0] e, bit cf, bit cab);
        logic [15:0] m;
        m = 16'hFFFF;
        if (!e[15]) m &= ~16'h6000;
        if (!e[11]) m &= ~16'h0600;
        if (!e[8])  m &= ~16'h00C0;
        if (!cf)    m &= ~16'h000E;
        if (!cab)   m &= ~16'h0030;
        q.push_back('{tag, opc, ack, tk, e, m});
    endtask

    task automatic push_instr(string t, logic [6:0] opc, logic [2:0] f, logic a, logic b, kind_e k,
                              int fw, int mw, logic tk, bit st, bit cut = 1'b0);
        logic [15:0] ops, e;
        logic [1:0]  pcs, wbs;
        ops = {10'b0, a, b, f, 1'b0};
        if (st) add({t, "/start"}, opc, 1'b0, tk, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < fw; i++) add({t, "/fetch_wait"}, opc, 1'b0, tk, 16'h8000, 1'b0, 1'b0);
        add({t, "/fetch"}, opc, 1'b1, tk, 16'h9000, 1'b0, 1'b0);
        add({t, "/decode"}, opc, rnd(), tk, ops, 1'b1, 1'b1);
        e = ops;
        if (k == K_BRANCH) e |= tk ? 16'h0A00 : 16'h0800;
        if (k == K_FENCE)  e |= 16'h0800;
        add({t, "/execute"}, opc, rnd(), tk, e, 1'b0, 1'b1);
        if (k == K_LOAD || k == K_STORE) begin
            e = ops | 16'hA000 | (k == K_STORE ? 16'h4000 : 16'h0000);
            for (int i = 0; i < mw; i++) add({t, "/mem_wait"}, opc, 1'b0, tk, e, 1'b0, 1'b1);
            if (!cut) add({t, "/mem_ack"}, opc, 1'b1, tk, e | (k == K_STORE ? 16'h0800 : 16'h0000), 1'b0, 1'b1);
        end
        if (!cut && k inside {K_ALU, K_LOAD, K_JAL, K_JALR}) begin
            wbs = k == K_LOAD ? 2'b01 : (k == K_JAL || k == K_JALR) ? 2'b10 : 2'b00;
            pcs = k == K_JAL ? 2'b01 : k == K_JALR ? 2'b10 : 2'b00;
            add({t, "/writeback"}, opc, rnd(), tk, ops | 16'h0900 | {5'b0, pcs, 1'b0, wbs, 6'b0}, 1'b0, 1'b1);
        end
    endtask

    task automatic push_trap(string t, logic [6:0] opc, int n, bit st);
        if (st) add({t, "/start"}, opc, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        add({t, "/fetch"}, opc, 1'b1, 1'b0, 16'h9000, 1'b0, 1'b0);
        add({t, "/decode"}, opc, rnd(), 1'b0, 16'h000E, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) add({t, "/trap"}, opc, rnd(), 1'b0, 16'h0001, 1'b0, 1'b0);
    endtask

    task automatic drain();
        ent_t        e;
        logic [15:0] o;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            opcode       = e.opc;
            branch_taken = e.tk;
            ifc.mem_ack  = e.ack;
            #1;
            o = obs_vec();
            n_checks++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h (mask %h)", e.tag, o, e.exp, e.mask);
            end
        end
    endtask

    task automatic do_reset(string t);
        logic [15:0] o;
        rst = 1'b1;
        ifc.mem_ack = 1'b1;
        #1;
        o = obs_vec();
        n_checks++;
        if (o !== 16'h0000) begin
            n_fail++;
            $display("FAIL %s/async: got %h expected 0000", t, o);
        end
        repeat (2) @(posedge clk);
        #1;
        o = obs_vec();
        n_checks++;
        if (o !== 16'h0000) begin
            n_fail++;
            $display("FAIL %s/held: got %h expected 0000", t, o);
        end
        #1;
        rst = 1'b0;
        ifc.mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        do_reset("reset");
    endtask

    task automatic test_addi();
        push_instr("addi", 7'b0010011, 3'b001, 1'b0, 1'b1, K_ALU, 0, 0, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_load_wait();
        push_instr("load_w3", 7'b0000011, 3'b001, 1'b0, 1'b1, K_LOAD, 0, 3, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_store();
        push_instr("store", 7'b0100011, 3'b010, 1'b0, 1'b1, K_STORE, 2, 1, 1'b0, 1'b0);
        push_instr("store_z", 7'b0100011, 3'b010, 1'b0, 1'b1, K_STORE, 0, 0, 1'b1, 1'b0);
        drain();
    endtask

    task automatic test_branch();
        push_instr("beq_t", 7'b1100011, 3'b011, 1'b1, 1'b1, K_BRANCH, 0, 0, 1'b1, 1'b0);
        push_instr("beq_nt", 7'b1100011, 3'b011, 1'b1, 1'b1, K_BRANCH, 1, 0, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_jumps();
        push_instr("jal", 7'b1101111, 3'b101, 1'b1, 1'b1, K_JAL, 0, 0, 1'b0, 1'b0);
        push_instr("jalr", 7'b1100111, 3'b001, 1'b0, 1'b1, K_JALR, 0, 0, 1'b1, 1'b0);
        drain();
    endtask

    task automatic test_back_to_back();
        push_instr("lui", 7'b0110111, 3'b100, 1'b0, 1'b1, K_ALU, 0, 0, 1'b0, 1'b0);
        push_instr("auipc", 7'b0010111, 3'b100, 1'b1, 1'b1, K_ALU, 1, 0, 1'b1, 1'b0);
        push_instr("add", 7'b0110011, 3'b000, 1'b0, 1'b0, K_ALU, 0, 0, 1'b0, 1'b0);
        push_instr("fence", 7'b0001111, 3'b001, 1'b0, 1'b1, K_FENCE, 0, 0, 1'b1, 1'b0);
        push_instr("load", 7'b0000011, 3'b001, 1'b0, 1'b1, K_LOAD, 2, 0, 1'b0, 1'b0);
        push_instr("addi2", 7'b0010011, 3'b001, 1'b0, 1'b1, K_ALU, 0, 0, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_trap();
        push_trap("illegal0", 7'b0000000, 20, 1'b0);
        drain();
        do_reset("trap_reset");
        push_trap("system", 7'b1110011, 3, 1'b1);
        drain();
        do_reset("sys_reset");
        push_instr("after_trap", 7'b0010011, 3'b001, 1'b0, 1'b1, K_ALU, 0, 0, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_reset_mid_mem();
        push_instr("ld_cut", 7'b0000011, 3'b001, 1'b0, 1'b1, K_LOAD, 0, 2, 1'b0, 1'b0, 1'b1);
        drain();
        do_reset("mid_mem_reset");
        push_instr("restart", 7'b0010011, 3'b001, 1'b0, 1'b1, K_ALU, 1, 0, 1'b0, 1'b1);
        drain();
    endtask

    initial begin
        ifc.mem_ack = 1'b0;
        test_reset();
        test_addi();
        test_load_wait();
        test_store();
        test_branch();
        test_jumps();
        test_back_to_back();
        test_trap();
        test_reset_mid_mem();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32i_multicycle_controller.md
RV32I_MULTICYCLE_CONTROLLER -- requirements
Module: rv32i_multicycle_controller

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (passed through to the format decoder; no width-dependent logic here).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port opcode  input  7  instruction[6:0] from the registered IR.
REQ-005 SHALL have port branch_taken  input  1  comparator result, valid in EXECUTE.
REQ-006 SHALL have port mem_ack  input  1  one-cycle completion pulse from the memory port.
REQ-007 SHALL have port mem_req  output  1  memory access request.
REQ-008 SHALL have port mem_we  output  1  write enable: 1 = store.
REQ-009 SHALL have port mem_sel  output  1  address select: 0 = PC, 1 = ALU result.
REQ-010 SHALL have port ir_we  output  1  IR load strobe.
REQ-011 SHALL have port pc_we  output  1  PC load strobe.
REQ-012 SHALL have port pc_sel  output  2  next-PC select: 00 = PC+4, 01 = ALU target, 10 = ALU target with bit0 cleared.
REQ-013 SHALL have port reg_we  output  1  register file write strobe.
REQ-014 SHALL have port wb_sel  output  2  write-back select: 00 = ALU, 01 = memory, 10 = PC+4.
REQ-015 SHALL have port alu_src_a  output  1  ALU operand A: 0 = rs1, 1 = PC.
REQ-016 SHALL have port alu_src_b  output  1  ALU operand B: 0 = rs2, 1 = immediate.
REQ-017 SHALL have port imm_format  output  3  format code: R=000, I=001, S=010, B=011, U=100, J=101, ILLEGAL=111.
REQ-018 SHALL have port illegal  output  1  sticky trap flag.

Function
REQ-019 SHALL implement a registered FSM with states START, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP; all outputs decode combinationally from state and opcode.
REQ-020 START: all strobes 0; unconditional transition to FETCH.
REQ-021 FETCH: mem_req=1, mem_sel=0, mem_we=0; remain in FETCH until mem_ack; on mem_ack, ir_we=1 and transition to DECODE.
REQ-022 DECODE: imm_format is driven from opcode (lui/auipc U, jal J, jalr/load/op-imm/fence I, branch B, store S, op R, all others ILLEGAL); ILLEGAL or system opcode goes to TRAP, otherwise to EXECUTE.
REQ-023 EXECUTE, routing by opcode:
- op/op-imm/lui/auipc/jal/jalr go to WRITEBACK.
- load/store go to MEMORY.
- branch: pc_we=1, pc_sel=01 if branch_taken else 00; then FETCH.
- fence: pc_we=1, pc_sel=00; then FETCH.
REQ-024 Operand selection: alu_src_a=1 for auipc/jal/branch; alu_src_b=1 for every non-R format. Values hold from DECODE through WRITEBACK.
REQ-025 MEMORY: mem_req=1, mem_sel=1, mem_we=1 for store only; remain until mem_ack. On mem_ack: load goes to WRITEBACK; store asserts pc_we=1, pc_sel=00 and goes to FETCH.
REQ-026 WRITEBACK: reg_we=1, pc_we=1, then FETCH.
- wb_sel=01 for load, 10 for jal/jalr, 00 otherwise.
- pc_sel=01 for jal, 10 for jalr, 00 otherwise.
REQ-027 Handshake: mem_req, mem_sel and mem_we SHALL stay stable from assertion until the mem_ack cycle; mem_ack in any other state is ignored.
REQ-028 Latency with zero-wait memory (mem_ack in the first request cycle), measured in cycles from FETCH entry:
- ALU/jump: 4.
- Load: 5.
- Store: 4.
- Branch/fence: 3.
Each memory wait cycle adds one.
REQ-029 TRAP: illegal=1; all strobes and mem_req 0; the FSM SHALL stay in TRAP until reset.
REQ-030 pc_we and reg_we SHALL each be asserted at most once per instruction.

Reset
REQ-031 While rst=1: state=START and every output 0, including mem_req and illegal, effective asynchronously without waiting for a clock edge.
REQ-032 Reset asserted mid-access SHALL drop mem_req in the same cycle; a mem_ack arriving during reset is ignored.
REQ-033 After release: one START cycle, then FETCH.

Structure
REQ-034 Shared package rv32i_pkg SHALL hold opcode constants, format codes, state encoding, and the pc_sel and wb_sel codes.
REQ-035 The opcode-to-format mapping SHALL be a combinational sub-module instr_format_decode, reused by the immediate path.

Verification
REQ-036 The bench SHALL cover the following directed scenarios:
- Reset, then opcode 0010011 (addi), mem_ack immediate -> START, FETCH, DECODE, EXECUTE, WRITEBACK; reg_we=1 in the WRITEBACK cycle; imm_format=001, alu_src_b=1, wb_sel=00.
- Load with mem_ack delayed 3 cycles -> mem_req=1, mem_sel=1, mem_we=0 held 4 cycles; then WRITEBACK with wb_sel=01.
- Branch with branch_taken=1 -> pc_we=1, pc_sel=01 in EXECUTE, reg_we never set; with branch_taken=0 -> pc_sel=00.
- jal -> imm_format=101, wb_sel=10, pc_sel=01; jalr -> imm_format=001, pc_sel=10.
- Opcode 0000000 -> TRAP, illegal=1, mem_req stays 0 for 20 cycles until reset.
- rst asserted during a MEMORY wait -> mem_req=0 immediately; after release, one START cycle, then FETCH.
